// File: rtl/mopshub_uplink_arbiter_pkg.sv
// Shared types and constants for the MOPSHUB uplink arbiter.
package mopshub_arb_pkg;

  localparam int N_BUS_MAX  = 16;
  localparam int ARB_SEL_W  = 5;

  typedef logic [ARB_SEL_W-1:0] sel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mopshub_uplink_arbiter_rr_mask_encoder.sv
// Round-robin winner search over the eligible mask, wrapping at n_buses.
module rr_mask_encoder #(
  parameter int N_BUS = 16,
  parameter int SEL_W = 5
) (
  input  logic [N_BUS-1:0] i_mask,
  input  logic [SEL_W-1:0] i_last_grant,
  input  logic [SEL_W-1:0] i_n_buses,
  output logic [SEL_W-1:0] o_winner,
  output logic             o_any
);

  int w_nb;
  int w_start;
  int w_dist;
  int w_best;

  // Each candidate gets its round-robin distance from the start point; smallest wins.
  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    w_best   = N_BUS;
    w_dist   = 0;
    w_nb     = (int'(i_n_buses) > N_BUS - 1) ? N_BUS - 1 : int'(i_n_buses);
    w_start  = (int'(i_last_grant) >= w_nb) ? 0 : int'(i_last_grant) + 1;
    for (int i = 0; i < N_BUS; i++) begin
      if (i_mask[i] && (i <= w_nb)) begin
        w_dist = (i >= w_start) ? (i - w_start) : (i + w_nb + 1 - w_start);
        if (w_dist < w_best) begin
          w_best   = w_dist;
          o_winner = SEL_W'(i);
          o_any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mopshub_uplink_arbiter.sv
// Round-robin scheduler for the shared CAN-to-Elink uplink path.
// Optional grant watchdog: define MOPSHUB_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for an eligible bus; winner registered on exit
// GRANT   | rec_valid high, select held until ready (or watchdog)
// RELEASE | ack/irq pulse visible; bus gets a cycle to update bus_req
module mopshub_uplink_arbiter
  import mopshub_arb_pkg::*;
#(
  parameter int N_BUS       = N_BUS_MAX,
  parameter int SEL_W       = ARB_SEL_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] n_buses,
  input  logic [N_BUS-1:0] bus_req,
  output logic [N_BUS-1:0] bus_ack,
  output logic [SEL_W-1:0] can_rec_select,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic             irq_elink_rec,
  output logic             busy,
  output logic             timeout_err,
  output logic [SEL_W-1:0] timeout_bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  arb_state_e       r_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_last_grant;
  logic [N_BUS-1:0] r_ack;
  logic             r_valid;
  logic             r_irq;
  logic             r_busy;
  logic [N_BUS-1:0] w_elig;
  logic [SEL_W-1:0] w_winner;
  logic             w_any;
`ifdef MOPSHUB_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_terr;
  logic [SEL_W-1:0] r_tbus;
`endif

  always_comb begin
    for (int i = 0; i < N_BUS; i++) begin
      w_elig[i] = bus_req[i] && (i <= int'(n_buses));
    end
  end

  rr_mask_encoder #(
    .N_BUS (N_BUS),
    .SEL_W (SEL_W)
  ) u_rr_mask_encoder (
    .i_mask       (w_elig),
    .i_last_grant (r_last_grant),
    .i_n_buses    (n_buses),
    .o_winner     (w_winner),
    .o_any        (w_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_last_grant <= SEL_W'(N_BUS - 1);
      r_ack        <= '0;
      r_valid      <= 1'b0;
      r_irq        <= 1'b0;
      r_busy       <= 1'b0;
`ifdef MOPSHUB_ARB_TIMEOUT_EN
      r_cnt        <= '0;
      r_terr       <= 1'b0;
      r_tbus       <= '0;
`endif
    end else begin
      r_ack   <= '0;
      r_irq   <= 1'b0;
`ifdef MOPSHUB_ARB_TIMEOUT_EN
      r_terr  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel   <= w_winner;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= GRANT;
`ifdef MOPSHUB_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        GRANT: begin
          // A ready in the watchdog's final cycle still counts as a normal transfer.
          if (rec_ready) begin
            r_ack        <= {{(N_BUS-1){1'b0}}, 1'b1} << r_sel;
            r_irq        <= 1'b1;
            r_last_grant <= r_sel;
            r_valid      <= 1'b0;
            r_state      <= RELEASE;
          end
`ifdef MOPSHUB_ARB_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            r_ack        <= {{(N_BUS-1){1'b0}}, 1'b1} << r_sel;
            r_terr       <= 1'b1;
            r_tbus       <= r_sel;
            r_last_grant <= r_sel;
            r_valid      <= 1'b0;
            r_state      <= RELEASE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus_ack        = r_ack;
  assign can_rec_select = r_sel;
  assign rec_valid      = r_valid;
  assign irq_elink_rec  = r_irq;
  assign busy           = r_busy;
`ifdef MOPSHUB_ARB_TIMEOUT_EN
  assign timeout_err    = r_terr;
  assign timeout_bus    = r_tbus;
`else
  assign timeout_err    = 1'b0;
  assign timeout_bus    = '0;
`endif

endmodule

// File: tb/tb_mopshub_uplink_arbiter.sv
// Bench for mopshub_uplink_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_mopshub_uplink_arbiter;

`ifdef MOPSHUB_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  n_buses = 5'd15;
  logic [15:0] bus_req = '0;
  logic [15:0] bus_ack;
  logic [4:0]  can_rec_select;
  logic        rec_valid;
  logic        rec_ready = 1'b0;
  logic        irq_elink_rec;
  logic        busy;
  logic        timeout_err;
  logic [4:0]  timeout_bus;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state (transaction view: phase 0 idle, 1 granted, 2 released)
  int          m_phase;
  int          m_sel;
  int          m_lg;
  int          m_wait;
  logic [15:0] m_ack;
  bit          m_irq, m_valid, m_busy, m_terr;
  int          m_tbus;

  always #5 clk = ~clk;

  mopshub_uplink_arbiter #(
    .N_BUS       (16),
    .SEL_W       (5),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .n_buses        (n_buses),
    .bus_req        (bus_req),
    .bus_ack        (bus_ack),
    .can_rec_select (can_rec_select),
    .rec_valid      (rec_valid),
    .rec_ready      (rec_ready),
    .irq_elink_rec  (irq_elink_rec),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .timeout_bus    (timeout_bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Winner = first requesting bus after the last grant, counting modulo the enabled bus count.
  function automatic bit pick(input logic [15:0] req, input int nb, input int lg, output int w);
    int n;
    int base;
    n    = (nb + 1 > 16) ? 16 : nb + 1;
    base = (lg > n - 1) ? 0 : lg + 1;
    w    = 0;
    for (int k = 0; k < n; k++) begin
      if (req[(base + k) % n]) begin
        w = (base + k) % n;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_sel = 0; m_lg = 15; m_wait = 0;
    m_ack = '0; m_irq = 0; m_valid = 0; m_busy = 0; m_terr = 0; m_tbus = 0;
  endtask

  task automatic model_step();
    int w;
    if (!rst) begin
      model_reset();
      return;
    end
    m_ack = '0; m_irq = 0; m_terr = 0;
    case (m_phase)
      0: if (pick(bus_req, int'(n_buses), m_lg, w)) begin
           m_sel = w; m_phase = 1; m_wait = 0;
         end
      1: if (rec_ready) begin
           m_ack = 16'd1 << m_sel; m_irq = 1; m_lg = m_sel; m_phase = 2;
         end
`ifdef MOPSHUB_ARB_TIMEOUT_EN
         else if (m_wait == TO - 1) begin
           m_ack = 16'd1 << m_sel; m_terr = 1; m_tbus = m_sel; m_lg = m_sel; m_phase = 2;
         end else begin
           m_wait++;
         end
`endif
      default: m_phase = 0;
    endcase
    m_valid = (m_phase == 1);
    m_busy  = (m_phase != 0);
  endtask

  task automatic compare_all();
    check_val("bus_ack", bus_ack, m_ack);
    check_val("select", can_rec_select, m_sel);
    check_val("rec_valid", rec_valid, m_valid);
    check_val("irq", irq_elink_rec, m_irq);
    check_val("busy", busy, m_busy);
    check_val("timeout_err", timeout_err, m_terr);
    check_val("timeout_bus", timeout_bus, m_tbus);
  endtask

  // Inputs change on the falling edge; model steps on the rising edge; outputs are compared on the next fall.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0; bus_req = '0; rec_ready = 1'b0; n_buses = 5'd15;
    model_reset();
    cyc(2);
    rst = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int got[$];
    int exp_order[5] = '{0, 5, 10, 15, 0};
    int rp;
    int hit;

    // reset values
    model_reset();
    #2;
    check_val("reset_outputs", {bus_ack, can_rec_select, rec_valid, irq_elink_rec, busy, timeout_err, timeout_bus}, 32'd0);
    reset_dut();

    // 1: single request, ready tied high
    bus_req = 16'h0001; rec_ready = 1'b1;
    cyc(1);
    check_val("t1_valid", rec_valid, 1);
    check_val("t1_sel", can_rec_select, 0);
    cyc(1);
    check_val("t1_ack", bus_ack, 16'h0001);
    check_val("t1_irq", irq_elink_rec, 1);
    bus_req = '0;
    cyc(2);
    check_val("t1_busy_done", busy, 0);

    // 2: fixed request pattern, round-robin order
    reset_dut();
    bus_req = 16'h8421; rec_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      if (bus_ack != '0) got.push_back(onehot_idx(bus_ack));
    end
    check_val("t2_grants", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) check_val("t2_order", got[i], exp_order[i]);

    // 3: requests only above n_buses, then an enabled one
    reset_dut();
    n_buses = 5'd3; bus_req = 16'hFFF0; rec_ready = 1'b1;
    cyc(5);
    check_val("t3_idle", busy, 0);
    bus_req = 16'hFFF4;
    cyc(1);
    check_val("t3_sel", can_rec_select, 2);

    // 4: ready held low on bus 4
    reset_dut();
    bus_req = 16'h0010;
    cyc(1);
    bus_req = '0;
`ifdef MOPSHUB_ARB_TIMEOUT_EN
    hit = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (timeout_err) begin hit = i; break; end
    end
    check_val("t4_timeout_cycles", hit, 8);
    check_val("t4_timeout_bus", timeout_bus, 4);
    check_val("t4_ack", bus_ack, 16'h0010);
    check_val("t4_no_irq", irq_elink_rec, 0);
`else
    cyc(100);
    check_val("t4_still_valid", rec_valid, 1);
    rec_ready = 1'b1;
    cyc(1);
    check_val("t4_ack", bus_ack, 16'h0010);
`endif

    // 5: reset asserted mid-grant
    reset_dut();
    bus_req = 16'h0080;
    cyc(2);
    rst = 1'b0;
    #1;
    check_val("t5_valid", rec_valid, 0);
    check_val("t5_busy", busy, 0);
    check_val("t5_sel", can_rec_select, 0);
    check_val("t5_ack", bus_ack, 0);
    model_reset();
    bus_req = 16'h0081; rec_ready = 1'b1;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    check_val("t5_first_winner", can_rec_select, 0);

    // 6: request dropped during grant
    reset_dut();
    bus_req = 16'h0004;
    cyc(1);
    bus_req = '0;
    cyc(5);
    rec_ready = 1'b1;
    cyc(1);
    check_val("t6_ack", bus_ack, 16'h0004);

    // random traffic
    reset_dut();
    rp = 70;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) rp = (rp == 70) ? 8 : 70;
      if ($urandom_range(0, 3) == 0) bus_req = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 9) == 0) n_buses = 5'($urandom_range(0, 20));
      rec_ready = ($urandom_range(0, 99) < rp);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
      end
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
